md_sequencer: RTL

Multiply/divide sequencer for the Execute stage. Accepts mult/multu/div/divu/mthi/mtlo operations from the E-stage operand path (after forwarding), runs them over a fixed multi-cycle latency, and owns the HI/LO registers. It raises a stall request to the hazard logic while an operation is pending and a Decode-stage instruction needs the unit, and it serialises back-to-back requests.

---
 rtl/md_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//   Multiply/divide sequencer for the Execute stage. Computes the result of a
//   mult/multu/div/divu when the operation is issued, holds it in pendHi/
//   pendLo while a down-counter models the unit latency, then commits it to
//   the architectural HI/LO registers. mthi/mtlo write HI/LO in one edge.
//
//   Handshake: start is a one-cycle issue strobe qualified only by the unit
//   being idle. While busy, start is dropped entirely (including mthi/mtlo);
//   the hazard unit must hold any D-stage user of the unit via stall_md, so no
//   issue is ever lost.
//
//   Configuration macro: MDU_DIV_EN
//     defined   -> div/divu supported (DIV_CYCLES latency)
//     undefined -> divider not built; div/divu act as reserved no-ops
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset, clears all state
//   start     in   E-stage instruction is a valid unit operation
//   mdop      in   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   srcA      in   forwarded rs operand
//   srcB      in   forwarded rt operand
//   md_use_D  in   D-stage instruction uses the unit
//   busy      out  operation in flight
//   stall_md  out  stall request to the hazard unit
//   hi, lo    out  HI/LO registers
//   mdState   out  FSM state (debug)
// ---------------------------------------------------------------------------
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [0:0]  mdState
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;

    logic             isMult;
    logic             isDiv;
    logic             isLong;
    logic [63:0]      prod;
    logic [31:0]      resHi;
    logic [31:0]      resLo;

    assign isMult = (mdop == OP_MULT) || (mdop == OP_MULTU);
`ifdef MDU_DIV_EN
    assign isDiv  = (mdop == OP_DIV) || (mdop == OP_DIVU);
`else
    assign isDiv  = 1'b0;
`endif
    assign isLong = isMult || isDiv;

    assign busy     = (state == RUN);
    assign mdState  = state;
    // Stall covers both an operation already running and one issuing now,
    // so a D-stage mfhi/mflo never reads a stale HI/LO.
    assign stall_md = md_use_D & (busy | (start & isLong));

    // Low 64 bits of the product of the 64-bit extended operands give the
    // signed or unsigned product depending on how the operands are extended.
    always_comb begin
        logic [63:0] aExt;
        logic [63:0] bExt;
        aExt = '0;
        bExt = '0;
        if (mdop == OP_MULT) begin
            aExt = {{32{srcA[31]}}, srcA};
            bExt = {{32{srcB[31]}}, srcB};
        end else begin
            aExt = {32'd0, srcA};
            bExt = {32'd0, srcB};
        end
        prod = aExt * bExt;
    end

`ifdef MDU_DIV_EN
    logic [31:0] quot;
    logic [31:0] rem;

    // Divide-by-zero and the single signed overflow case are resolved
    // explicitly so the result never depends on the simulator or the
    // synthesised divider's behaviour for those operands.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (srcB == 32'd0) begin
            quot = 32'hFFFF_FFFF;
            rem  = srcA;
        end else if (mdop == OP_DIV) begin
            if ((srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF)) begin
                quot = 32'h8000_0000;
                rem  = 32'd0;
            end else begin
                // Truncating division: remainder sign follows the dividend.
                quot = $signed(srcA) / $signed(srcB);
                rem  = $signed(srcA) % $signed(srcB);
            end
        end else begin
            quot = srcA / srcB;
            rem  = srcA % srcB;
        end
    end
`endif

    always_comb begin
        resHi = prod[63:32];
        resLo = prod[31:0];
`ifdef MDU_DIV_EN
        if (isDiv) begin
            resHi = rem;
            resLo = quot;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            pendHi <= '0;
            pendLo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (isLong) begin
                            pendHi <= resHi;
                            pendLo <= resLo;
                            cnt    <= isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state  <= RUN;
                        end else if (mdop == OP_MTHI) begin
                            hi <= srcA;
                        end else if (mdop == OP_MTLO) begin
                            lo <= srcA;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    // cnt == 0 cannot occur in RUN; treated as a final cycle
                    // so the FSM can never get stuck.
                    if (cnt <= CNT_W'(1)) begin
                        hi    <= pendHi;
                        lo    <= pendLo;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
